// File: rtl/controle_fp_pkg.sv
// Shared types and constants for the floating-point add sequencing controller.
package controle_fp_pkg;

  localparam int unsigned MAX_ALIGN = 26;

  // ULA mode selects: both ULAs run in add mode, big ULA never subtracts
  localparam logic ULA_MODE_ADD = 1'b1;
  localparam logic BIG_ULA_ADD  = 1'b0;

  // Exponent adjust direction and fraction shift direction
  localparam logic EXP_ADJ_ADD  = 1'b0;
  localparam logic EXP_ADJ_SUB  = 1'b1;
  localparam logic SHIFT_RIGHT  = 1'b0;
  localparam logic SHIFT_LEFT   = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    DIFF,
    ALIGN,
    EXP_LD,
    EXP_REL,
    NORM_LD,
    NORM_REL,
    CHECK,
    RN_LD,
    RN_REL,
    DONE
  } state_t;

endpackage

// File: rtl/controle_fp_contador_zeros_esquerda.sv
// Combinational leading-zero counter; an all-zero input yields FRAC_W.
module contador_zeros_esquerda #(
  parameter int unsigned FRAC_W = 26,
  parameter int unsigned SH_W   = 5
) (
  input  logic [FRAC_W-1:0] data,
  output logic [SH_W-1:0]   zeros_c
);

  int unsigned n;

  // Scan upward so the highest set bit has the final say
  always_comb begin
    n = FRAC_W;
    for (int unsigned i = 0; i < FRAC_W; i++) begin
      if (data[i]) n = FRAC_W - 1 - i;
    end
    zeros_c = SH_W'(n);
  end

endmodule

// File: rtl/controle_fp.sv
// Sequencer for the floating-point add datapath: drives the control word
// through align, exponent load, normalize and optional round re-normalize.
module controle_fp
  import controle_fp_pkg::*;
#(
  parameter int unsigned FRAC_W = 26,
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned SH_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              zero_result,
  input  logic              overflow,
  input  logic [EXP_W-1:0]  saida_registrador,
  input  logic [FRAC_W-1:0] data_out_big_ula,
  output logic              load,
  output logic [SH_W-1:0]   tamanho,
  output logic [SH_W-1:0]   tamanho2,
  output logic [EXP_W-1:0]  tamanho3,
  output logic              soma_multiplica_small_ula,
  output logic              soma_multiplica_big_ula,
  output logic              decisor_mux_expoente_escolhido,
  output logic              decisor_mux_saida_big_ula,
  output logic              decisor_shift_right_left,
  output logic              subtrador_big_ula,
  output logic              subtrador_Somador_subtrador
);

  state_t            state, state_n;
  logic [EXP_W-1:0]  diff, diff_n;
  logic [SH_W-1:0]   lz, lz_n, lz_c;
  logic              all_zero_c;

  logic              load_n, busy_n, done_n, zero_n;
  logic [SH_W-1:0]   tamanho_n, tamanho2_n;
  logic [EXP_W-1:0]  tamanho3_n;
  logic              mux_exp_n, mux_saida_n, shift_rl_n, sub_big_n, sub_som_n;

  contador_zeros_esquerda #(
    .FRAC_W (FRAC_W),
    .SH_W   (SH_W)
  ) u_lzc (
    .data    (data_out_big_ula),
    .zeros_c (lz_c)
  );

  assign all_zero_c = (lz_c == SH_W'(FRAC_W));

  // Next state, plus the registered control word of the state being entered
  always_comb begin
    state_n     = state;
    diff_n      = diff;
    lz_n        = lz;
    load_n      = 1'b0;
    done_n      = 1'b0;
    busy_n      = 1'b0;
    zero_n      = zero_result;
    tamanho_n   = tamanho;
    tamanho2_n  = tamanho2;
    tamanho3_n  = tamanho3;
    mux_exp_n   = decisor_mux_expoente_escolhido;
    mux_saida_n = decisor_mux_saida_big_ula;
    shift_rl_n  = decisor_shift_right_left;
    sub_big_n   = subtrador_big_ula;
    sub_som_n   = subtrador_Somador_subtrador;

    case (state)
      IDLE:     if (start) state_n = DIFF;
      DIFF:     state_n = ALIGN;
      ALIGN: begin
        diff_n  = saida_registrador;
        lz_n    = lz_c;
        state_n = all_zero_c ? DONE : EXP_LD;
      end
      EXP_LD:   state_n = EXP_REL;
      EXP_REL:  state_n = NORM_LD;
      NORM_LD:  state_n = NORM_REL;
      NORM_REL: state_n = CHECK;
      CHECK:    state_n = overflow ? RN_LD : DONE;
      RN_LD:    state_n = RN_REL;
      RN_REL:   state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);

    // Alignment shift is clamped so a huge exponent gap flushes the small operand
    if (state == ALIGN) begin
      tamanho_n = (saida_registrador > EXP_W'(MAX_ALIGN)) ? SH_W'(MAX_ALIGN)
                                                          : saida_registrador[SH_W-1:0];
      sub_big_n = BIG_ULA_ADD;
      zero_n    = all_zero_c;
    end

    case (state_n)
      IDLE: begin
        tamanho_n   = '0;
        tamanho2_n  = '0;
        tamanho3_n  = '0;
        mux_exp_n   = 1'b0;
        mux_saida_n = 1'b0;
        shift_rl_n  = 1'b0;
        sub_big_n   = 1'b0;
        sub_som_n   = 1'b0;
      end
      DIFF: zero_n = 1'b0;
      EXP_LD, EXP_REL: begin
        mux_exp_n   = 1'b0;
        sub_som_n   = EXP_ADJ_ADD;
        tamanho3_n  = diff_n;
        mux_saida_n = 1'b0;
        load_n      = (state_n == EXP_LD);
      end
      NORM_LD, NORM_REL: begin
        mux_exp_n   = 1'b1;
        mux_saida_n = 1'b0;
        // lz == 0 means the sum carried into the top bit: shift right by one
        if (lz_n == '0) begin
          shift_rl_n = SHIFT_RIGHT;
          tamanho2_n = SH_W'(1);
          sub_som_n  = EXP_ADJ_ADD;
          tamanho3_n = EXP_W'(1);
        end else begin
          shift_rl_n = SHIFT_LEFT;
          tamanho2_n = lz_n - SH_W'(1);
          sub_som_n  = EXP_ADJ_SUB;
          tamanho3_n = EXP_W'(lz_n - SH_W'(1));
        end
        load_n = (state_n == NORM_LD);
      end
      RN_LD, RN_REL: begin
        mux_saida_n = 1'b1;
        shift_rl_n  = SHIFT_RIGHT;
        tamanho2_n  = SH_W'(1);
        mux_exp_n   = 1'b1;
        sub_som_n   = EXP_ADJ_ADD;
        tamanho3_n  = EXP_W'(1);
        load_n      = (state_n == RN_LD);
      end
      DONE: done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                          <= IDLE;
      diff                           <= '0;
      lz                             <= '0;
      load                           <= 1'b0;
      busy                           <= 1'b0;
      done                           <= 1'b0;
      zero_result                    <= 1'b0;
      tamanho                        <= '0;
      tamanho2                       <= '0;
      tamanho3                       <= '0;
      soma_multiplica_small_ula      <= 1'b0;
      soma_multiplica_big_ula        <= 1'b0;
      decisor_mux_expoente_escolhido <= 1'b0;
      decisor_mux_saida_big_ula      <= 1'b0;
      decisor_shift_right_left       <= 1'b0;
      subtrador_big_ula              <= 1'b0;
      subtrador_Somador_subtrador    <= 1'b0;
    end else begin
      state                          <= state_n;
      diff                           <= diff_n;
      lz                             <= lz_n;
      load                           <= load_n;
      busy                           <= busy_n;
      done                           <= done_n;
      zero_result                    <= zero_n;
      tamanho                        <= tamanho_n;
      tamanho2                       <= tamanho2_n;
      tamanho3                       <= tamanho3_n;
      soma_multiplica_small_ula      <= ULA_MODE_ADD;
      soma_multiplica_big_ula        <= ULA_MODE_ADD;
      decisor_mux_expoente_escolhido <= mux_exp_n;
      decisor_mux_saida_big_ula      <= mux_saida_n;
      decisor_shift_right_left       <= shift_rl_n;
      subtrador_big_ula              <= sub_big_n;
      subtrador_Somador_subtrador    <= sub_som_n;
    end
  end

endmodule

// File: tb/tb_controle_fp.sv
// Randomized bench for controle_fp: a cycle-indexed model of each request
// is queued and compared against the DUT outputs on every falling edge.
module tb_controle_fp;

  typedef struct packed {
    logic       busy, done, zero, load, soma_s, soma_b;
    logic       mux_exp, mux_saida, rl, sub_big, sub_som;
    logic [4:0] tam, t2;
    logic [7:0] t3;
  } vec_t;

  typedef struct {
    int   idx;
    vec_t v;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset, start, overflow;
  logic [7:0]  saida;
  logic [25:0] dout_in;
  logic        busy, done, zero_result, load;
  logic [4:0]  tamanho, tamanho2;
  logic [7:0]  tamanho3;
  logic        soma_s, soma_b, mux_e, mux_s, rl, sub_big, sub_som;

  ent_t q[$];
  vec_t act_hist[16];
  int   errors = 0;
  int   checks = 0;
  bit   zero_model;

  always #5 clk = ~clk;

  controle_fp dut (
    .clk                            (clk),
    .reset                          (reset),
    .start                          (start),
    .busy                           (busy),
    .done                           (done),
    .zero_result                    (zero_result),
    .overflow                       (overflow),
    .saida_registrador              (saida),
    .data_out_big_ula               (dout_in),
    .load                           (load),
    .tamanho                        (tamanho),
    .tamanho2                       (tamanho2),
    .tamanho3                       (tamanho3),
    .soma_multiplica_small_ula      (soma_s),
    .soma_multiplica_big_ula        (soma_b),
    .decisor_mux_expoente_escolhido (mux_e),
    .decisor_mux_saida_big_ula      (mux_s),
    .decisor_shift_right_left       (rl),
    .subtrador_big_ula              (sub_big),
    .subtrador_Somador_subtrador    (sub_som)
  );

  function automatic int clz(input logic [25:0] v);
    for (int i = 25; i >= 0; i--) if (v[i]) return 25 - i;
    return 26;
  endfunction

  // Expected outputs k cycles after the accept edge's preceding IDLE cycle
  function automatic vec_t model(input int k, input logic [7:0] d, input int lz,
                                 input bit ovf, input bit zprev);
    vec_t e;
    int   last;
    bit   zr;
    e = '0;
    e.soma_s = 1'b1;
    e.soma_b = 1'b1;
    zr   = (lz == 26);
    last = zr ? 3 : (ovf ? 10 : 8);
    if (k == 0) begin
      e.zero = zprev;
      return e;
    end
    e.busy = 1'b1;
    if (k >= 3) e.tam = (d > 8'd26) ? 5'd26 : d[4:0];
    if (zr) begin
      if (k == last) begin
        e.zero = 1'b1;
        e.done = 1'b1;
      end
      return e;
    end
    if (k >= 3) e.t3 = d;
    if (k >= 5) begin
      e.mux_exp = 1'b1;
      if (lz == 0) begin
        e.t2 = 5'd1;
        e.t3 = 8'd1;
      end else begin
        e.rl      = 1'b1;
        e.t2      = 5'(lz - 1);
        e.sub_som = 1'b1;
        e.t3      = 8'(lz - 1);
      end
    end
    if (ovf && k >= 8) begin
      e.mux_saida = 1'b1;
      e.rl        = 1'b0;
      e.t2        = 5'd1;
      e.sub_som   = 1'b0;
      e.t3        = 8'd1;
    end
    e.load = (k == 3 || k == 5 || (ovf && k == 8));
    e.done = (k == last);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int first_done(input int last);
    for (int k = 0; k <= last; k++) if (act_hist[k].done) return k;
    return 99;
  endfunction

  function automatic int load_pulses(input int last);
    int n = 0;
    for (int k = 0; k <= last; k++)
      if (act_hist[k].load && (k == 0 || !act_hist[k-1].load)) n++;
    return n;
  endfunction

  task automatic step(input vec_t e, input int idx);
    @(posedge clk);
    #1;
    q.push_back('{idx: idx, v: e});
  endtask

  // One request; rst_at >= 0 pulses reset for 3 cycles starting in that cycle
  task automatic run_txn(input logic [7:0] d, input logic [25:0] dout, input bit ovf,
                         input bit hold, input int rst_at, output int last);
    int   lz;
    bit   zprev;
    vec_t e;
    lz    = clz(dout);
    zprev = zero_model;
    last  = (rst_at >= 0) ? rst_at + 4 : ((lz == 26) ? 3 : (ovf ? 10 : 8));
    for (int k = 0; k <= last; k++) begin
      if (rst_at < 0 || k <= rst_at) e = model(k, d, lz, ovf, zprev);
      else if (k <= rst_at + 3)      e = '0;
      else                           e = model(0, d, lz, ovf, 1'b0);
      step(e, k);
      reset = (rst_at >= 0 && k >= rst_at && k < rst_at + 3);
      if (k == 0) begin
        start   = 1'b1;
        saida   = d;
        dout_in = dout;
      end else begin
        start = (rst_at >= 0) ? 1'b0 : hold;
        if (k >= 3) begin
          saida   = 8'($urandom);
          dout_in = 26'($urandom);
        end
      end
      overflow = (k == 7) ? ovf : 1'($urandom_range(0, 1));
    end
    zero_model = (rst_at >= 0) ? 1'b0 : (lz == 26);
    @(negedge clk);
    #1;
  endtask

  // Per-cycle comparison against the queued model vectors
  initial begin
    ent_t e;
    vec_t a;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {busy, done, zero_result, load, soma_s, soma_b, mux_e, mux_s, rl,
             sub_big, sub_som, tamanho, tamanho2, tamanho3};
        if (e.idx < 16) act_hist[e.idx] = a;
        checks++;
        if (a !== e.v) begin
          errors++;
          $display("FAIL ctrl_word cycle=%0d t=%0t got=%h want=%h", e.idx, $time, a, e.v);
        end
      end
    end
  end

  initial begin
    int          last, lzt, gap;
    logic [7:0]  d;
    logic [25:0] dout, r;
    bit          ovf, hold;
    reset = 1'b1; start = 1'b0; overflow = 1'b0;
    saida = '0; dout_in = '0; zero_model = 1'b0;

    step('0, 0);
    step('0, 1);
    reset = 1'b0;
    step(model(0, 8'd0, 0, 1'b0, 1'b0), 2);
    @(negedge clk); #1;
    chk("reset_soma", int'(act_hist[1].soma_s), 0);
    chk("post_reset_soma", int'(act_hist[2].soma_b), 1);

    run_txn(8'd3, 26'h0800000, 1'b0, 1'b0, -1, last);
    chk("t1_done_cycle", first_done(last), 8);
    chk("t1_load_pulses", load_pulses(last), 2);
    chk("t1_tamanho", int'(act_hist[3].tam), 3);
    chk("t1_tamanho3_exp", int'(act_hist[3].t3), 3);
    chk("t1_sub_exp", int'(act_hist[3].sub_som), 0);
    chk("t1_tamanho2", int'(act_hist[5].t2), 1);
    chk("t1_left", int'(act_hist[5].rl), 1);
    chk("t1_tamanho3_norm", int'(act_hist[5].t3), 1);
    chk("t1_sub_norm", int'(act_hist[5].sub_som), 1);

    run_txn(8'd0, 26'h2000000, 1'b0, 1'b0, -1, last);
    chk("t2_done_cycle", first_done(last), 8);
    chk("t2_right", int'(act_hist[5].rl), 0);
    chk("t2_tamanho2", int'(act_hist[5].t2), 1);
    chk("t2_tamanho3", int'(act_hist[5].t3), 1);
    chk("t2_add", int'(act_hist[5].sub_som), 0);

    run_txn(8'd40, 26'h0001234, 1'b0, 1'b0, -1, last);
    chk("t3_tamanho_clamp", int'(act_hist[3].tam), 26);
    chk("t3_tamanho3", int'(act_hist[3].t3), 40);

    run_txn(8'd5, 26'h0400000, 1'b1, 1'b0, -1, last);
    chk("t4_done_cycle", first_done(last), 10);
    chk("t4_load_pulses", load_pulses(last), 3);
    chk("t4_mux_saida", int'(act_hist[8].mux_saida), 1);

    run_txn(8'd7, 26'h0, 1'b0, 1'b1, -1, last);
    chk("t5_done_cycle", first_done(last), 3);
    chk("t5_load_pulses", load_pulses(last), 0);
    chk("t5_zero", int'(act_hist[3].zero), 1);
    run_txn(8'd9, 26'h0100000, 1'b0, 1'b1, -1, last);
    chk("t5b_done_cycle", first_done(last), 8);

    run_txn(8'd12, 26'h0080000, 1'b0, 1'b0, 5, last);
    chk("rst_load_pulses", load_pulses(last), 2);
    chk("rst_outputs_zero", int'(act_hist[6] != '0), 0);
    chk("rst_no_load_after", int'(act_hist[9].load), 0);

    for (int n = 0; n < 40; n++) begin
      d    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 30));
      lzt  = $urandom_range(0, 26);
      if (lzt == 26) dout = '0;
      else begin
        r    = 26'($urandom);
        dout = (26'd1 << (25 - lzt)) | (r & ((26'd1 << (25 - lzt)) - 26'd1));
      end
      ovf  = 1'($urandom_range(0, 1));
      hold = (n < 38) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_txn(d, dout, ovf, hold, -1, last);
      if (!hold) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          step(model(0, 8'd0, 0, 1'b0, zero_model), 0);
          start = 1'b0;
        end
      end
    end

    start = 1'b0;
    step(model(0, 8'd0, 0, 1'b0, zero_model), 0);
    step(model(0, 8'd0, 0, 1'b0, zero_model), 0);
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/controle_fp.md
# controle_fp

Sequencing controller for the floating-point add datapath, the `Datapath` exponent/fraction pipeline. It accepts a start request and drives the datapath control word state by state: exponent difference, alignment, exponent load, normalization, rounding re-normalization. It computes alignment and normalization shift amounts from datapath status and signals completion. The requester reads the result on the datapath's `saida_final` when `done` pulses.

## Interface
Parameters:
- FRAC_W, 26, fraction/ULA width
- EXP_W, 8, exponent width
- SH_W, 5, shifter amount width

Ports:
- clk  in  1  system clock; rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE inclusive
- done  out  1  one-cycle pulse; result valid on datapath output
- zero_result  out  1  set with done when the aligned sum is zero; held until next accept
- overflow  in  1  rounding overflow from datapath
- saida_registrador  in  EXP_W  registered exponent difference
- data_out_big_ula  in  FRAC_W  big-ULA result
- load  out  1  exponent-latch strobe (datapath latches on its rising edge)
- tamanho  out  SH_W  alignment right-shift
- tamanho2  out  SH_W  normalization shift
- tamanho3  out  EXP_W  exponent adjust amount
- soma_multiplica_small_ula, soma_multiplica_big_ula  out  1 each  constant 1 (add mode) outside reset
- decisor_mux_expoente_escolhido, decisor_mux_saida_big_ula, decisor_shift_right_left, subtrador_big_ula, subtrador_Somador_subtrador  out  1 each  datapath selects

## Operation
- States: IDLE, DIFF, ALIGN, EXP_LD, EXP_REL, NORM_LD, NORM_REL, CHECK, RN_LD, RN_REL, DONE.
- IDLE: start=1 -> DIFF. Requester holds input_1/input_2 stable until done.
- DIFF: the small ULA subtracts; the difference register captures the result at this edge. Next state ALIGN.
- ALIGN: register `diff` = saida_registrador.
  - tamanho = (diff > 26) ? 26 : diff[4:0].
  - subtrador_big_ula = 0.
  - Register `lz` = leading-zero count of data_out_big_ula (0..26).
  - If lz == 26 -> DONE with zero_result=1. Otherwise -> EXP_LD.
- EXP_LD/EXP_REL:
  - Selects: mux_expoente=0, subtrador_Somador=0, tamanho3=diff, mux_saida=0.
  - load=1 in EXP_LD and 0 in EXP_REL. This latches the larger exponent.
- NORM_LD/NORM_REL:
  - Selects: mux_expoente=1, mux_saida=0.
  - If lz == 0 (carry into bit 25): decisor_shift_right_left=0, tamanho2=1, subtrador_Somador=0, tamanho3=1.
  - Else: decisor_shift_right_left=1, tamanho2=lz-1, subtrador_Somador=1, tamanho3=lz-1.
  - load pulses high in NORM_LD.
- CHECK: overflow=1 -> RN_LD. Otherwise -> DONE.
- RN_LD/RN_REL:
  - Selects: mux_saida=1, decisor_shift_right_left=0, tamanho2=1, mux_expoente=1, subtrador_Somador=0, tamanho3=1.
  - load pulses in RN_LD. Then -> DONE. At most one re-normalization; CHECK is not revisited.
- DONE: done=1 -> IDLE. A start in DONE is ignored.
- Select outputs hold their last state-defined values; IDLE drives all to 0.
- Reset: every output 0 (including load, busy, done, zero_result), diff=0, lz=0, state IDLE, effective next edge from any state. load falls and never rises during reset, so no spurious exponent latch.

## Timing
- All outputs are registered (Moore). load is glitch-free, high exactly one cycle, low for at least one cycle between pulses.
- Take the start-accept edge as cycle 0:
  - Nonzero result, no overflow: DIFF=1, ALIGN=2, EXP_LD=3, NORM_LD=5, CHECK=7, done in cycle 8.
  - With overflow: RN_LD=8, done in cycle 10.
  - Zero result: done in cycle 3; no load pulse.
- lz is sampled only in ALIGN; later changes on data_out_big_ula are ignored.
- overflow is sampled only in CHECK.

## Structure
- Package `controle_fp_pkg` holds:
  - the state enum;
  - MAX_ALIGN=26;
  - add-mode constants for the ULA selects.
- One sub-module, `contador_zeros_esquerda`: a combinational FRAC_W-bit leading-zero counter with output width SH_W.

## Test plan
- Reset: hold reset 3 cycles mid-run (in NORM_LD). Expect all outputs 0, state IDLE, and no further load edge.
- Stub with diff=3 and data_out=26'h0800000 (lz=2). Expect:
  - tamanho=3, tamanho3=3 with subtrador 0, then tamanho2=1 left and tamanho3=1 with subtrador 1;
  - two load pulses;
  - done in cycle 8.
- diff=0 and data_out bit25=1 (lz=0). Expect right shift tamanho2=1, tamanho3=1 add, done in cycle 8.
- diff=40. Expect tamanho=26 and tamanho3=40.
- overflow=1 in CHECK. Expect RN states with mux_saida=1, three load pulses, done in cycle 10.
- data_out=0. Expect zero_result=1, done in cycle 3, no load. Also, start held high through DONE must produce exactly one accept per IDLE visit.
